yarp_data_mem_resp: RTL and testbench

- Memory-side responder for the core's load/store control outputs: data_req, data_byte, data_wr and zero_extnd.
- Serves scalar BYTE/HALF_WORD/WORD accesses and 128-bit vector accesses (V_TYPE_LOAD/V_TYPE_STORE, VECTOR_REG_WIDTH) from one single-port, 32-bit-word RAM.
- A vector access is sequenced as 4 word beats.
- Sits between the core's load/store path / VRF and the data RAM model used by the test benches.

---
 rtl/yarp_data_mem_resp.sv | 210 +++++++++++++++++++++
 tb/tb_yarp_data_mem_resp.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/yarp_data_mem_resp.sv
// Scalar/vector data-memory responder over one single-port 32-bit RAM.
// Optional `YARP_MEM_ALIGN_CHK_EN`: reject misaligned/reserved accesses via err_o.
module yarp_data_mem_resp #(
  parameter int MEM_WORDS = 1024,
  parameter int VLEN      = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            data_req_i,
  input  logic [31:0]     data_addr_i,
  input  logic [1:0]      data_byte_i,
  input  logic            data_wr_i,
  input  logic [31:0]     data_wr_data_i,
  input  logic            zero_extnd_i,
  output logic            data_gnt_o,
  output logic            data_rvalid_o,
  output logic [31:0]     data_rd_data_o,
  input  logic            vdata_req_i,
  input  logic            vdata_wr_i,
  input  logic [31:0]     vdata_addr_i,
  input  logic [VLEN-1:0] vdata_wr_data_i,
  output logic            vdata_gnt_o,
  output logic            vdata_rvalid_o,
  output logic [VLEN-1:0] vdata_rd_data_o,
  output logic            err_o
);
  // state | meaning
  // IDLE  | accept scalar (priority) or vector request
  // VBEAT | one vector word per cycle, beat cnt_q = 0..3
  // VDONE | vector response pulse
  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [1:0] BYTE = 2'b00, HALF_WORD = 2'b01, WORD = 2'b11;

  typedef enum logic [1:0] {IDLE, VBEAT, VDONE} state_t;

  if (VLEN != 128) begin : g_bad_vlen
    $error("yarp_data_mem_resp: VLEN must be 128");
  end
  if ((1 << AW) != MEM_WORDS || AW < 2) begin : g_bad_depth
    $error("yarp_data_mem_resp: MEM_WORDS must be a power of two >= 4");
  end

  logic [31:0] mem [MEM_WORDS];

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [AW-3:0]     vbase_q, vbase_d;
  logic              vwr_q, vwr_d;
  logic [VLEN-1:0]   vwdata_q, vwdata_d;
  logic              verr_q, verr_d;
  logic [95:0]       vstage_q, vstage_d;
  logic [VLEN-1:0]   vrd_q, vrd_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rd_q, rd_d;
  logic              serr_q, serr_d;

  logic              s_err, v_err;
  logic [AW-1:0]     s_idx, v_idx, ram_idx;
  logic [1:0]        s_off;
  logic [31:0]       s_word, v_word, s_load, s_wdata, ram_wdata;
  logic [7:0]        s_byte;
  logic [15:0]       s_half;
  logic [3:0]        s_be, ram_be;
  logic              ram_we;
  logic              unused_ok;

  assign unused_ok = ^{data_addr_i[31:AW+2], vdata_addr_i[31:AW+2], vdata_addr_i[3:0]};

  always_comb begin
    s_err = 1'b0;
    v_err = 1'b0;
`ifdef YARP_MEM_ALIGN_CHK_EN
    s_err = (data_byte_i == HALF_WORD && data_addr_i[0]) ||
            (data_byte_i == WORD && data_addr_i[1:0] != 2'b00) ||
            (data_byte_i == 2'b10);
    v_err = (vdata_addr_i[3:0] != 4'h0);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (vdata_gnt_o) state_d = VBEAT;
      VBEAT:   if (cnt_q == 2'd3) state_d = VDONE;
      VDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_gnt_o     = (state_q == IDLE) & data_req_i;
    vdata_gnt_o    = (state_q == IDLE) & vdata_req_i & ~data_req_i;
    vdata_rvalid_o = (state_q == VDONE);
    err_o          = (rvalid_q & serr_q) | ((state_q == VDONE) & verr_q);
  end

  assign data_rvalid_o   = rvalid_q;
  assign data_rd_data_o  = rd_q;
  assign vdata_rd_data_o = vrd_q;

  always_comb begin
    s_idx  = data_addr_i[AW+1:2];
    s_off  = data_addr_i[1:0];
    s_word = mem[s_idx];
    s_byte = s_word[{s_off, 3'b000} +: 8];
    s_half = s_word[{s_off[1], 4'b0000} +: 16];
    v_idx  = {vbase_q, cnt_q};
    v_word = mem[v_idx];

    // Reserved size 10 falls through to WORD
    case (data_byte_i)
      BYTE: begin
        s_load  = {{24{~zero_extnd_i & s_byte[7]}}, s_byte};
        s_wdata = {4{data_wr_data_i[7:0]}};
        s_be    = 4'b0001 << s_off;
      end
      HALF_WORD: begin
        s_load  = {{16{~zero_extnd_i & s_half[15]}}, s_half};
        s_wdata = {2{data_wr_data_i[15:0]}};
        s_be    = s_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        s_load  = s_word;
        s_wdata = data_wr_data_i;
        s_be    = 4'b1111;
      end
    endcase

    ram_we    = 1'b0;
    ram_idx   = s_idx;
    ram_be    = s_be;
    ram_wdata = s_wdata;
    if (data_gnt_o && data_wr_i && !s_err) begin
      ram_we = 1'b1;
    end else if (state_q == VBEAT && vwr_q && !verr_q) begin
      ram_we    = 1'b1;
      ram_idx   = v_idx;
      ram_be    = 4'b1111;
      ram_wdata = vwdata_q[32*cnt_q +: 32];
    end

    rvalid_d = data_gnt_o;
    serr_d   = data_gnt_o & s_err;
    rd_d     = rd_q;
    if (data_gnt_o) rd_d = (data_wr_i || s_err) ? 32'h0 : s_load;

    vbase_d  = vbase_q;
    vwr_d    = vwr_q;
    vwdata_d = vwdata_q;
    verr_d   = verr_q;
    if (vdata_gnt_o) begin
      vbase_d  = vdata_addr_i[AW+1:4];
      vwr_d    = vdata_wr_i;
      vwdata_d = vdata_wr_data_i;
      verr_d   = v_err;
    end

    cnt_d    = (state_q == VBEAT) ? cnt_q + 2'd1 : 2'd0;
    vstage_d = vstage_q;
    vrd_d    = vrd_q;
    // Stage beats 0..2 so the visible vector data only changes on completion
    if (state_q == VBEAT && !vwr_q) begin
      case (cnt_q)
        2'd0:    vstage_d[31:0]  = v_word;
        2'd1:    vstage_d[63:32] = v_word;
        2'd2:    vstage_d[95:64] = v_word;
        default: vrd_d = verr_q ? '0 : {v_word, vstage_q};
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= 2'd0;
      vbase_q  <= '0;
      vwr_q    <= 1'b0;
      vwdata_q <= '0;
      verr_q   <= 1'b0;
      vstage_q <= '0;
      vrd_q    <= '0;
      rvalid_q <= 1'b0;
      rd_q     <= 32'h0;
      serr_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      vbase_q  <= vbase_d;
      vwr_q    <= vwr_d;
      vwdata_q <= vwdata_d;
      verr_q   <= verr_d;
      vstage_q <= vstage_d;
      vrd_q    <= vrd_d;
      rvalid_q <= rvalid_d;
      rd_q     <= rd_d;
      serr_q   <= serr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) mem[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_yarp_data_mem_resp.sv
// Directed bench for yarp_data_mem_resp; expectations follow YARP_MEM_ALIGN_CHK_EN when defined.
module tb_yarp_data_mem_resp;
  logic         clk = 1'b0;
  logic         reset;
  logic         data_req_i, data_wr_i, zero_extnd_i;
  logic [31:0]  data_addr_i, data_wr_data_i;
  logic [1:0]   data_byte_i;
  logic         data_gnt_o, data_rvalid_o, err_o;
  logic [31:0]  data_rd_data_o;
  logic         vdata_req_i, vdata_wr_i;
  logic [31:0]  vdata_addr_i;
  logic [127:0] vdata_wr_data_i, vdata_rd_data_o;
  logic         vdata_gnt_o, vdata_rvalid_o;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] VDATA_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] VDATA_B = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
  localparam logic [127:0] VDATA_C = 128'hBBBB008C_BBBB0088_BBBB0084_BBBB0080;

  yarp_data_mem_resp dut (
    .clk(clk), .reset(reset),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_byte_i(data_byte_i),
    .data_wr_i(data_wr_i), .data_wr_data_i(data_wr_data_i), .zero_extnd_i(zero_extnd_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rd_data_o(data_rd_data_o),
    .vdata_req_i(vdata_req_i), .vdata_wr_i(vdata_wr_i), .vdata_addr_i(vdata_addr_i),
    .vdata_wr_data_i(vdata_wr_data_i), .vdata_gnt_o(vdata_gnt_o),
    .vdata_rvalid_o(vdata_rvalid_o), .vdata_rd_data_o(vdata_rd_data_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_scalar(input logic wr, input logic [31:0] addr, input logic [1:0] sz,
                              input logic [31:0] wd, input logic zx,
                              output logic gnt, output logic rv, output logic [31:0] rd,
                              output logic er);
    @(posedge clk); #1;
    data_req_i = 1'b1; data_wr_i = wr; data_addr_i = addr; data_byte_i = sz;
    data_wr_data_i = wd; zero_extnd_i = zx;
    @(negedge clk); gnt = data_gnt_o;
    @(posedge clk); #1;
    data_req_i = 1'b0; data_wr_i = 1'b0;
    @(negedge clk); rv = data_rvalid_o; rd = data_rd_data_o; er = err_o;
  endtask

  task automatic drive_vector(input logic wr, input logic [31:0] addr, input logic [127:0] wd,
                              output logic gnt, output int lat, output logic [127:0] rd,
                              output logic er);
    @(posedge clk); #1;
    vdata_req_i = 1'b1; vdata_wr_i = wr; vdata_addr_i = addr; vdata_wr_data_i = wd;
    @(negedge clk); gnt = vdata_gnt_o;
    @(posedge clk); #1;
    vdata_req_i = 1'b0; vdata_wr_i = 1'b0;
    lat = 0; rd = '0; er = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (vdata_rvalid_o) begin
        lat = i; rd = vdata_rd_data_o; er = err_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    data_req_i = 0; data_wr_i = 0; data_addr_i = 0; data_byte_i = 0; data_wr_data_i = 0;
    zero_extnd_i = 0; vdata_req_i = 0; vdata_wr_i = 0; vdata_addr_i = 0; vdata_wr_data_i = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({data_gnt_o, data_rvalid_o, data_rd_data_o, vdata_gnt_o, vdata_rvalid_o,
         vdata_rd_data_o, err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b rv=%b rd=%h vgnt=%b vrv=%b vrd=%h err=%b expected all 0",
               data_gnt_o, data_rvalid_o, data_rd_data_o, vdata_gnt_o, vdata_rvalid_o,
               vdata_rd_data_o, err_o);
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    data_req_i = 1; data_wr_i = 1; data_addr_i = 32'h10; data_byte_i = 2'b11;
    data_wr_data_i = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (data_gnt_o !== 1'b1) begin errors++; $display("FAIL sw_gnt: got %b expected 1", data_gnt_o); end
    @(posedge clk); #1;
    data_wr_i = 0;
    @(negedge clk);
    checks++; if ({data_gnt_o, data_rvalid_o, data_rd_data_o} !== {2'b11, 32'h0}) begin
      errors++; $display("FAIL sw_resp: got gnt=%b rv=%b rd=%h expected gnt=1 rv=1 rd=0", data_gnt_o, data_rvalid_o, data_rd_data_o); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if ({data_rvalid_o, data_rd_data_o} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL lw1_resp: got rv=%b rd=%h expected rv=1 rd=deadbeef", data_rvalid_o, data_rd_data_o); end
    @(posedge clk); #1;
    data_req_i = 0;
    @(negedge clk);
    checks++; if ({data_rvalid_o, data_rd_data_o} !== {1'b1, 32'hDEADBEEF}) begin
      errors++; $display("FAIL lw2_resp: got rv=%b rd=%h expected rv=1 rd=deadbeef", data_rvalid_o, data_rd_data_o); end
    @(negedge clk);
    checks++; if ({data_rvalid_o, data_rd_data_o} !== {1'b0, 32'hDEADBEEF}) begin
      errors++; $display("FAIL rd_hold: got rv=%b rd=%h expected rv=0 rd=deadbeef", data_rvalid_o, data_rd_data_o); end
  endtask

  task automatic test_byte_half();
    logic g, rv, er;
    logic [31:0] rd;
    drive_scalar(1, 32'h20, 2'b11, 32'h0, 0, g, rv, rd, er);
    drive_scalar(1, 32'h21, 2'b00, 32'h12345680, 0, g, rv, rd, er);
    checks++; if ({g, rv, rd} !== {2'b11, 32'h0}) begin errors++; $display("FAIL sb_resp: got gnt=%b rv=%b rd=%h expected 1 1 0", g, rv, rd); end
    drive_scalar(0, 32'h21, 2'b00, 32'h0, 0, g, rv, rd, er);
    checks++; if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_21: got %h expected ffffff80", rd); end
    drive_scalar(0, 32'h21, 2'b00, 32'h0, 1, g, rv, rd, er);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_21: got %h expected 00000080", rd); end
    drive_scalar(0, 32'h20, 2'b01, 32'h0, 1, g, rv, rd, er);
    checks++; if (rd !== 32'h00008000) begin errors++; $display("FAIL lhu_20: got %h expected 00008000", rd); end
    drive_scalar(1, 32'h22, 2'b01, 32'hCAFEBEEF, 0, g, rv, rd, er);
    drive_scalar(0, 32'h22, 2'b01, 32'h0, 0, g, rv, rd, er);
    checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh_22: got %h expected ffffbeef", rd); end
    drive_scalar(0, 32'h20, 2'b11, 32'h0, 0, g, rv, rd, er);
    checks++; if (rd !== 32'hBEEF8000) begin errors++; $display("FAIL lw_20_lanes: got %h expected beef8000", rd); end
  endtask

  task automatic test_vector();
    logic g, er, sg, srv, ser;
    int lat;
    logic [127:0] vrd;
    logic [31:0] rd;
    drive_vector(1, 32'h40, VDATA_A, g, lat, vrd, er);
    checks++; if ({g, lat, vrd, er} !== {1'b1, 32'd5, 128'h0, 1'b0}) begin
      errors++; $display("FAIL vs_40: got gnt=%b lat=%0d vrd=%h err=%b expected 1 5 0 0", g, lat, vrd, er); end
    drive_vector(0, 32'h40, 128'h0, g, lat, vrd, er);
    checks++; if ({g, lat, vrd, er} !== {1'b1, 32'd5, VDATA_A, 1'b0}) begin
      errors++; $display("FAIL vl_40: got gnt=%b lat=%0d vrd=%h err=%b expected 1 5 %h 0", g, lat, vrd, er, VDATA_A); end
    drive_scalar(0, 32'h4C, 2'b11, 32'h0, 0, sg, srv, rd, ser);
    checks++; if (rd !== 32'h44444444) begin errors++; $display("FAIL lw_4c: got %h expected 44444444", rd); end
    drive_scalar(0, 32'h40, 2'b11, 32'h0, 0, sg, srv, rd, ser);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL lw_40: got %h expected 11111111", rd); end
    drive_vector(1, 32'h1FF0, VDATA_B, g, lat, vrd, er);
    checks++; if ({lat, vrd} !== {32'd5, VDATA_A}) begin
      errors++; $display("FAIL vs_wrap_hold: got lat=%0d vrd=%h expected 5 %h", lat, vrd, VDATA_A); end
    drive_scalar(0, 32'hFF0, 2'b11, 32'h0, 0, sg, srv, rd, ser);
    checks++; if (rd !== 32'hD0D0D0D0) begin errors++; $display("FAIL wrap_ff0: got %h expected d0d0d0d0", rd); end
    drive_scalar(0, 32'hFFC, 2'b11, 32'h0, 0, sg, srv, rd, ser);
    checks++; if (rd !== 32'hD3D3D3D3) begin errors++; $display("FAIL wrap_ffc: got %h expected d3d3d3d3", rd); end
  endtask

  task automatic test_simultaneous();
    int lat;
    @(posedge clk); #1;
    data_req_i = 1; data_wr_i = 0; data_addr_i = 32'h10; data_byte_i = 2'b11;
    vdata_req_i = 1; vdata_wr_i = 0; vdata_addr_i = 32'h40;
    @(negedge clk);
    checks++; if ({data_gnt_o, vdata_gnt_o} !== 2'b10) begin errors++; $display("FAIL both_gnt_n: got gnt=%b vgnt=%b expected 1 0", data_gnt_o, vdata_gnt_o); end
    @(posedge clk); #1;
    data_req_i = 0;
    @(negedge clk);
    checks++; if ({data_rvalid_o, data_rd_data_o, vdata_gnt_o} !== {1'b1, 32'hDEADBEEF, 1'b1}) begin
      errors++; $display("FAIL both_n1: got rv=%b rd=%h vgnt=%b expected 1 deadbeef 1", data_rvalid_o, data_rd_data_o, vdata_gnt_o); end
    @(posedge clk); #1;
    vdata_req_i = 0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (vdata_rvalid_o) begin lat = i + 1; break; end
    end
    checks++; if (lat != 6 || vdata_rd_data_o !== VDATA_A) begin
      errors++; $display("FAIL both_vrv: got latency N+%0d vrd=%h expected N+6 %h", lat, vdata_rd_data_o, VDATA_A); end
  endtask

  task automatic test_reset_mid_vector();
    logic g, rv, er, seen;
    logic [31:0] rd;
    drive_scalar(1, 32'h80, 2'b11, 32'h0, 0, g, rv, rd, er);
    drive_scalar(1, 32'h84, 2'b11, 32'h0, 0, g, rv, rd, er);
    drive_scalar(1, 32'h88, 2'b11, 32'hAAAA0088, 0, g, rv, rd, er);
    drive_scalar(1, 32'h8C, 2'b11, 32'hAAAA008C, 0, g, rv, rd, er);
    @(posedge clk); #1;
    vdata_req_i = 1; vdata_wr_i = 1; vdata_addr_i = 32'h80; vdata_wr_data_i = VDATA_C;
    @(negedge clk);
    checks++; if (vdata_gnt_o !== 1'b1) begin errors++; $display("FAIL mid_gnt: got %b expected 1", vdata_gnt_o); end
    @(posedge clk); #1;
    vdata_req_i = 0; vdata_wr_i = 0;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({vdata_rvalid_o, vdata_gnt_o, data_rd_data_o} !== 34'h0) begin
      errors++; $display("FAIL mid_reset_out: got vrv=%b vgnt=%b rd=%h expected 0 0 0", vdata_rvalid_o, vdata_gnt_o, data_rd_data_o); end
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (vdata_rvalid_o) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_vrv: got vrv seen=%b expected 0", seen); end
    drive_scalar(0, 32'h80, 2'b11, 32'h0, 0, g, rv, rd, er);
    checks++; if (rd !== 32'hBBBB0080) begin errors++; $display("FAIL mid_80: got %h expected bbbb0080", rd); end
    drive_scalar(0, 32'h84, 2'b11, 32'h0, 0, g, rv, rd, er);
    checks++; if (rd !== 32'hBBBB0084) begin errors++; $display("FAIL mid_84: got %h expected bbbb0084", rd); end
    drive_scalar(0, 32'h88, 2'b11, 32'h0, 0, g, rv, rd, er);
    checks++; if (rd !== 32'hAAAA0088) begin errors++; $display("FAIL mid_88: got %h expected aaaa0088", rd); end
    drive_scalar(0, 32'h8C, 2'b11, 32'h0, 0, g, rv, rd, er);
    checks++; if (rd !== 32'hAAAA008C) begin errors++; $display("FAIL mid_8c: got %h expected aaaa008c", rd); end
  endtask

  task automatic test_misalign();
    logic g, rv, er, vg, ver;
    logic [31:0] rd;
    logic [127:0] vrd;
    int lat;
`ifdef YARP_MEM_ALIGN_CHK_EN
    drive_scalar(0, 32'h13, 2'b11, 32'h0, 0, g, rv, rd, er);
    checks++; if ({rv, er, rd} !== {2'b11, 32'h0}) begin errors++; $display("FAIL lw_13_err: got rv=%b err=%b rd=%h expected 1 1 0", rv, er, rd); end
    drive_scalar(0, 32'h11, 2'b01, 32'h0, 0, g, rv, rd, er);
    checks++; if ({rv, er, rd} !== {2'b11, 32'h0}) begin errors++; $display("FAIL lh_11_err: got rv=%b err=%b rd=%h expected 1 1 0", rv, er, rd); end
    drive_scalar(0, 32'h10, 2'b10, 32'h0, 0, g, rv, rd, er);
    checks++; if ({rv, er, rd} !== {2'b11, 32'h0}) begin errors++; $display("FAIL sz10_err: got rv=%b err=%b rd=%h expected 1 1 0", rv, er, rd); end
    drive_scalar(1, 32'h12, 2'b11, 32'h55555555, 0, g, rv, rd, er);
    drive_scalar(0, 32'h10, 2'b11, 32'h0, 0, g, rv, rd, er);
    checks++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL sw_err_nowrite: got err=%b rd=%h expected 0 deadbeef", er, rd); end
    drive_vector(0, 32'h44, 128'h0, vg, lat, vrd, ver);
    checks++; if ({lat, ver, vrd} !== {32'd5, 1'b1, 128'h0}) begin errors++; $display("FAIL vl_44_err: got lat=%0d err=%b vrd=%h expected 5 1 0", lat, ver, vrd); end
`else
    drive_scalar(0, 32'h13, 2'b11, 32'h0, 0, g, rv, rd, er);
    checks++; if ({rv, er, rd} !== {2'b10, 32'hDEADBEEF}) begin errors++; $display("FAIL lw_13_align: got rv=%b err=%b rd=%h expected 1 0 deadbeef", rv, er, rd); end
    drive_scalar(0, 32'h11, 2'b01, 32'h0, 0, g, rv, rd, er);
    checks++; if ({er, rd} !== {1'b0, 32'hFFFFBEEF}) begin errors++; $display("FAIL lh_11_align: got err=%b rd=%h expected 0 ffffbeef", er, rd); end
    drive_scalar(0, 32'h10, 2'b10, 32'h0, 0, g, rv, rd, er);
    checks++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("FAIL sz10_word: got err=%b rd=%h expected 0 deadbeef", er, rd); end
    drive_vector(0, 32'h44, 128'h0, vg, lat, vrd, ver);
    checks++; if ({lat, ver, vrd} !== {32'd5, 1'b0, VDATA_A}) begin errors++; $display("FAIL vl_44_align: got lat=%0d err=%b vrd=%h expected 5 0 %h", lat, ver, vrd, VDATA_A); end
`endif
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_byte_half();
    test_vector();
    test_simultaneous();
    test_misalign();
    test_reset_mid_vector();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
